// File: rtl/std_divmod_pkg.sv
// Shared types and elaboration helpers for the iterative divide/modulo primitive.
//   div_state_e : controller states (idle, iterate, sign fix-up, done pulse, hold-off)
//   iters()     : number of iteration cycles, WIDTH / STEPS
//   cnt_width() : width of the iteration counter, clog2(iters + 1), never below 1
package std_divmod_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StFix,
    StDone,
    StHold
  } div_state_e;

  function automatic int unsigned iters(int unsigned width, int unsigned steps);
    return (steps == 0) ? 0 : width / steps;
  endfunction

  function automatic int unsigned cnt_width(int unsigned width, int unsigned steps);
    int unsigned w;
    w = $clog2(iters(width, steps) + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/std_div_step.sv
// One combinational restoring-division step.
//   rem_i          : partial remainder entering the step (always < divisor)
//   divisor_i      : divisor magnitude
//   dividend_bit_i : next dividend bit, MSB first
//   rem_o          : partial remainder leaving the step
//   quot_bit_o     : resolved quotient bit
module std_div_step #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] rem_i,
  input  logic [Width-1:0] divisor_i,
  input  logic             dividend_bit_i,
  output logic [Width-1:0] rem_o,
  output logic             quot_bit_o
);

  // The shifted remainder needs one guard bit; after a conditional subtract it fits in Width.
  logic [Width:0] partial;
  logic [Width:0] diff;

  always_comb begin
    partial    = {rem_i, dividend_bit_i};
    diff       = partial - {1'b0, divisor_i};
    quot_bit_o = (partial >= {1'b0, divisor_i});
    rem_o      = quot_bit_o ? diff[Width-1:0] : partial[Width-1:0];
  end

endmodule

// File: rtl/std_divmod_iter.sv
// Multi-cycle integer divider (quotient + remainder) with a go/done handshake.
// STEPS restoring steps per cycle, optional two's-complement mode truncating toward zero.
//   clk, reset    : clock, synchronous active-high reset
//   go            : start/hold request, held until done is seen; dropping it aborts
//   left, right   : dividend and divisor, sampled on the start edge only
//   out_quotient  : registered quotient
//   out_remainder : registered remainder (sign of the dividend in signed mode)
//   div_by_zero   : registered, set when the last completed operation had right == 0
//   done          : one-cycle completion pulse
module std_divmod_iter
  import std_divmod_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned STEPS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             div_by_zero,
  output logic             done
);

  localparam int unsigned N    = iters(WIDTH, STEPS);
  localparam int unsigned CntW = cnt_width(WIDTH, STEPS);

  if (STEPS == 0 || (WIDTH % STEPS) != 0) begin : g_bad_steps
    $error("std_divmod_iter: STEPS must be non-zero and divide WIDTH");
  end

  div_state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  // dq holds the dividend magnitude; quotient bits shift in from the LSB as it drains.
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             sign_l_q, sign_l_d;
  logic             sign_r_q, sign_r_d;
  logic             dbz_q, dbz_d;

  logic             neg_l, neg_r;
  logic [WIDTH-1:0] abs_l, abs_r;
  logic [WIDTH-1:0] fix_quot, fix_rem;
  logic             load_out;

  logic [WIDTH-1:0] chain_rem [STEPS+1];
  logic [STEPS-1:0] chain_q;

  // Operand magnitudes; MIN maps onto 2^(WIDTH-1) as an unsigned value.
  always_comb begin
    neg_l = SIGNED & left[WIDTH-1];
    neg_r = SIGNED & right[WIDTH-1];
    abs_l = neg_l ? -left : left;
    abs_r = neg_r ? -right : right;
  end

  assign chain_rem[0] = rem_q;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    std_div_step #(
      .Width(WIDTH)
    ) u_step (
      .rem_i         (chain_rem[g]),
      .divisor_i     (divisor_q),
      .dividend_bit_i(dq_q[WIDTH-1-g]),
      .rem_o         (chain_rem[g+1]),
      .quot_bit_o    (chain_q[STEPS-1-g])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (go) begin
          state_d = (right == '0 || left == '0) ? StFix : StCalc;
        end
      end
      StCalc: begin
        if (!go) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(N - 1)) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = go ? StDone : StIdle;
      StDone:  state_d = go ? StHold : StIdle;
      StHold: begin
        if (!go) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    done     = (state_q == StDone);
    load_out = (state_q == StFix) && go;
  end

  // Datapath next state.
  always_comb begin
    cnt_d     = cnt_q;
    dq_d      = dq_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    sign_l_d  = sign_l_q;
    sign_r_d  = sign_r_q;
    dbz_d     = dbz_q;
    case (state_q)
      StIdle: begin
        if (go) begin
          cnt_d     = '0;
          sign_l_d  = neg_l;
          sign_r_d  = neg_r;
          divisor_d = abs_r;
          if (right == '0) begin
            // Divide-by-zero results are staged raw and bypass the sign fix-up.
            dq_d  = '1;
            rem_d = left;
            dbz_d = 1'b1;
          end else begin
            // A zero dividend leaves dq = rem = 0, which is already the answer.
            dq_d  = abs_l;
            rem_d = '0;
            dbz_d = 1'b0;
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q + CntW'(1);
        dq_d  = (dq_q << STEPS) | WIDTH'(chain_q);
        rem_d = chain_rem[STEPS];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      dq_q      <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      sign_l_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dq_q      <= dq_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      sign_l_q  <= sign_l_d;
      sign_r_q  <= sign_r_d;
      dbz_q     <= dbz_d;
    end
  end

  // Sign fix-up; MIN / -1 wraps back to MIN without a flag.
  always_comb begin
    if (dbz_q) begin
      fix_quot = dq_q;
      fix_rem  = rem_q;
    end else begin
      fix_quot = (SIGNED && (sign_l_q ^ sign_r_q)) ? -dq_q : dq_q;
      fix_rem  = (SIGNED && sign_l_q) ? -rem_q : rem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_quotient  <= '0;
      out_remainder <= '0;
      div_by_zero   <= 1'b0;
    end else if (load_out) begin
      out_quotient  <= fix_quot;
      out_remainder <= fix_rem;
      div_by_zero   <= dbz_q;
    end
  end

endmodule

// File: tb/tb_std_divmod_iter.sv
module tb_std_divmod_iter;

  localparam int unsigned W = 8;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         go_u  = 1'b0;
  logic         go_s  = 1'b0;
  logic [W-1:0] left  = '0;
  logic [W-1:0] right = '0;
  logic [W-1:0] q_u, r_u, q_s, r_s;
  logic         dbz_u, dbz_s, done_u, done_s;

  bit sel;  // 0: unsigned DUT, 1: signed DUT
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  std_divmod_iter #(
    .WIDTH (W),
    .SIGNED(1'b0),
    .STEPS (2)
  ) u_dut_u (
    .clk          (clk),
    .reset        (reset),
    .go           (go_u),
    .left         (left),
    .right        (right),
    .out_quotient (q_u),
    .out_remainder(r_u),
    .div_by_zero  (dbz_u),
    .done         (done_u)
  );

  std_divmod_iter #(
    .WIDTH (W),
    .SIGNED(1'b1),
    .STEPS (2)
  ) u_dut_s (
    .clk          (clk),
    .reset        (reset),
    .go           (go_s),
    .left         (left),
    .right        (right),
    .out_quotient (q_s),
    .out_remainder(r_s),
    .div_by_zero  (dbz_s),
    .done         (done_s)
  );

  typedef struct packed {
    bit           s;
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic [W-1:0] q;
    logic [W-1:0] rm;
    bit           dbz;
    logic [3:0]   lat;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [W-1:0] q_now();
    return sel ? q_s : q_u;
  endfunction
  function automatic logic [W-1:0] r_now();
    return sel ? r_s : r_u;
  endfunction
  function automatic logic dbz_now();
    return sel ? dbz_s : dbz_u;
  endfunction
  function automatic logic done_now();
    return sel ? done_s : done_u;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_go(input logic v);
    if (sel) go_s = v;
    else go_u = v;
  endtask

  task automatic start_op(input bit s, input logic [W-1:0] l, input logic [W-1:0] r);
    sel   = s;
    left  = l;
    right = r;
    set_go(1'b1);
  endtask

  // Counts edges until done rises (bounded) and checks the count.
  task automatic wait_done(input string name, input int lat);
    int  edges;
    bit  seen;
    edges = 0;
    seen  = 0;
    while (!seen && edges < 20) begin
      tick();
      edges++;
      if (done_now() === 1'b1) seen = 1;
    end
    check({name, " latency"}, edges, lat);
  endtask

  task automatic check_out(input string name, input logic [W-1:0] q, input logic [W-1:0] rm,
                           input bit dbz);
    check({name, " quotient"}, q_now(), q);
    check({name, " remainder"}, r_now(), rm);
    check({name, " div_by_zero"}, dbz_now(), dbz);
  endtask

  // Full handshake: start, done after lat edges, single-cycle pulse, release go.
  task automatic run_vec(input string name, input vec_t v);
    start_op(v.s, v.l, v.r);
    wait_done(name, int'(v.lat));
    check_out(name, v.q, v.rm, v.dbz);
    tick();
    check({name, " done pulse width"}, done_now(), 1'b0);
    set_go(1'b0);
    tick();
  endtask

  initial begin
    //          s     left   right  quot   rem    dbz   lat
    vecs[0]  = '{1'b0, 8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 4'd6};
    vecs[1]  = '{1'b1, 8'hF9,  8'd2,   8'hFD,  8'hFF, 1'b0, 4'd6};
    vecs[2]  = '{1'b1, 8'd7,   8'hFE,  8'hFD,  8'h01, 1'b0, 4'd6};
    vecs[3]  = '{1'b1, 8'h80,  8'hFF,  8'h80,  8'h00, 1'b0, 4'd6};
    vecs[4]  = '{1'b0, 8'd5,   8'd0,   8'hFF,  8'd5,  1'b1, 4'd2};
    vecs[5]  = '{1'b0, 8'd9,   8'd3,   8'd3,   8'd0,  1'b0, 4'd6};
    vecs[6]  = '{1'b0, 8'd100, 8'd9,   8'd11,  8'd1,  1'b0, 4'd6};
    vecs[7]  = '{1'b0, 8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 4'd2};
    vecs[8]  = '{1'b1, 8'hF9,  8'd0,   8'hFF,  8'hF9, 1'b1, 4'd2};
    vecs[9]  = '{1'b0, 8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 4'd6};
    vecs[10] = '{1'b0, 8'd3,   8'd200, 8'd0,   8'd3,  1'b0, 4'd6};
    vecs[11] = '{1'b1, 8'h9C,  8'd7,   8'hF2,  8'hFE, 1'b0, 4'd6};
    vecs[12] = '{1'b1, 8'd100, 8'hF9,  8'hF2,  8'h02, 1'b0, 4'd6};

    // Reset state of both instances.
    tick();
    tick();
    sel = 0;
    check_out("reset unsigned", 8'h00, 8'h00, 1'b0);
    check("reset unsigned done", done_u, 1'b0);
    sel = 1;
    check_out("reset signed", 8'h00, 8'h00, 1'b0);
    check("reset signed done", done_s, 1'b0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Abort: prior result 9/3, start 200/7, drop go after edge 3.
    run_vec("abort prior", '{1'b0, 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 4'd6});
    start_op(1'b0, 8'd200, 8'd7);
    tick();
    tick();
    tick();
    go_u = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_u !== 1'b0) check("abort no done", done_u, 1'b0);
    end
    check_out("abort hold", 8'd3, 8'd0, 1'b0);
    // Restart 100/9; operand changes after the start edge must be ignored.
    start_op(1'b0, 8'd100, 8'd9);
    tick();
    left  = 8'd255;
    right = 8'd1;
    wait_done("restart", 5);
    check_out("restart", 8'd11, 8'd1, 1'b0);
    tick();
    go_u = 1'b0;
    tick();

    // Reset mid-CALC with go still high at release.
    start_op(1'b0, 8'd200, 8'd7);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_out("midcalc reset", 8'h00, 8'h00, 1'b0);
    check("midcalc reset done", done_u, 1'b0);
    reset = 1'b0;
    wait_done("after reset", 6);
    check_out("after reset", 8'd28, 8'd4, 1'b0);

    // go held 5 cycles after done: no second pulse; then low one cycle and restart.
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold cycle%0d done", i), done_u, 1'b0);
    end
    go_u = 1'b0;
    tick();
    start_op(1'b0, 8'd50, 8'd6);
    wait_done("rearm", 6);
    check_out("rearm", 8'd8, 8'd2, 1'b0);
    tick();
    go_u = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
